// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the FSM state encoding, bytes-per-word and checksum width.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int BPW = 4;
  localparam int CSW = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream (ByteIn/ByteValid/ByteReady) plus imem write port.
// slave = loader side, master = stream source / memory side.
interface imem_loader_if #(
  parameter int AWL = 8,
  parameter int WL  = 32
);

  logic [7:0]     ByteIn;
  logic           ByteValid;
  logic           ByteReady;
  logic           IMWE;
  logic [AWL-1:0] IMWA;
  logic [WL-1:0]  IMWD;

  modport master (
    output ByteIn,
    output ByteValid,
    input  ByteReady,
    input  IMWE,
    input  IMWA,
    input  IMWD
  );

  modport slave (
    input  ByteIn,
    input  ByteValid,
    output ByteReady,
    output IMWE,
    output IMWA,
    output IMWD
  );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian word assembler: shift in bytes, flag the 4th of a word.
// Ports: CLK, RST, clear, shift, din -> word, word_full.
module byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int WL = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          shift,
  input  logic [7:0]    din,
  output logic [WL-1:0] word,
  output logic          word_full
);

  logic [1:0]    cnt;
  logic [WL-1:0] sr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[WL-9:0], din};
      cnt <= cnt + 2'd1;
    end
  end

  assign word      = sr;
  assign word_full = shift & (cnt == 2'(BPW - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into imem, verifies XOR checksum, releases core.
// Ports: CLK, RST, Start, WordCount, bus (stream+imem), CoreRST/Busy/Done/Error.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int AWL = 8,
  parameter int WL  = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Start,
  input  logic [AWL:0]  WordCount,
  imem_loader_if.slave  bus,
  output logic          CoreRST,
  output logic          Busy,
  output logic          Done,
  output logic          Error
);

  state_t         state;
  state_t         nxt;
  logic [AWL-1:0] addr;
  logic [AWL:0]   wc;
  logic [AWL:0]   wcm1;
  logic [CSW-1:0] csum;
  logic [WL-1:0]  word;
  logic           word_full;
  logic           start_ok;
  logic           rx;
  logic           cx;
  logic           too_big;
  logic           last;

  assign start_ok = Start & ((state == IDLE) |
                             (state == DONE) |
                             (state == ERR));
  assign rx       = bus.ByteValid & (state == RECV);
  assign cx       = bus.ByteValid & (state == CHECK);
  assign too_big  = WordCount[AWL] & (|WordCount[AWL-1:0]);
  assign wcm1     = wc - 1'b1;
  assign last     = ({1'b0, addr} == wcm1);

  byte_assembler #(.WL(WL)) u_asm (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (start_ok),
    .shift     (rx),
    .din       (bus.ByteIn),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          if (WordCount == '0) nxt = DONE;
          else if (too_big)    nxt = ERR;
          else                 nxt = RECV;
        end
      end
      RECV:  if (word_full) nxt = WRITE;
      WRITE: nxt = last ? CHECK : RECV;
      CHECK: begin
        if (cx) nxt = (bus.ByteIn == csum) ? DONE : ERR;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      addr    <= '0;
      wc      <= '0;
      csum    <= '0;
      CoreRST <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else begin
      state <= nxt;
      if (start_ok) begin
        addr <= '0;
        csum <= '0;
        wc   <= WordCount;
      end else begin
        if (state == WRITE) addr <= addr + 1'b1;
        if (rx)             csum <= csum ^ bus.ByteIn;
      end
      // Status flags track the state being entered so they line up
      // with the edge that moves the FSM.
      CoreRST <= (nxt != DONE);
      Busy    <= (nxt == RECV) | (nxt == WRITE) | (nxt == CHECK);
      Done    <= (nxt == DONE);
      Error   <= (nxt == ERR);
    end
  end

  assign bus.ByteReady = (state == RECV) | (state == CHECK);
  assign bus.IMWE      = (state == WRITE);
  assign bus.IMWA      = addr;
  assign bus.IMWD      = word;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus,
// popped and compared by a monitor on every IMWE cycle.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AWL = 8;
  localparam int WL  = 32;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           Start = 1'b0;
  logic [AWL:0]   WordCount = '0;
  logic           CoreRST;
  logic           Busy;
  logic           Done;
  logic           Error;

  imem_loader_if #(.AWL(AWL), .WL(WL)) bus ();

  imem_loader #(.AWL(AWL), .WL(WL)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .WordCount (WordCount),
    .bus       (bus.slave),
    .CoreRST   (CoreRST),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AWL-1:0] a;
    logic [WL-1:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          checks = 0;
  int          errors = 0;
  int          last_a = -1;
  int          nwr = 0;
  int          cyc = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin : mon
    wr_t e;
    if (RST === 1'b1 && bus.IMWE === 1'b1) begin
      chk("rdy_in_write", {63'd0, bus.ByteReady}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                 bus.IMWA, bus.IMWD);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {56'd0, bus.IMWA}, {56'd0, e.a});
        chk("wr_data", {32'd0, bus.IMWD}, {32'd0, e.d});
      end
      last_a = int'(bus.IMWA);
      nwr++;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int   n = 0;
    logic r = 1'b0;
    bit   got = 1'b0;
    if (gap > 0) begin
      bus.ByteValid = 1'b0;
      repeat (gap) begin
        @(negedge CLK);
        cyc++;
      end
    end
    bus.ByteIn    = b;
    bus.ByteValid = 1'b1;
    while (!got && n < 20) begin
      r = bus.ByteReady;
      @(negedge CLK);
      n++;
      cyc++;
      got = r;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %0h not accepted, waited %0d", b, n);
    end
  endtask

  task automatic do_start(input int wc);
    WordCount = (AWL + 1)'(wc);
    Start     = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    cyc   = 0;
  endtask

  task automatic load(input logic [7:0] flip, input int maxgap);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    wr_t        e;
    for (int i = 0; i < words.size(); i++) begin
      e.a = AWL'(i);
      e.d = words[i];
      exp_q.push_back(e);
    end
    // First byte already valid on the Start cycle; it must not be eaten.
    bus.ByteIn    = words[0][31:24];
    bus.ByteValid = 1'b1;
    do_start(words.size());
    for (int i = 0; i < words.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[i][31-8*k -: 8];
        cs = cs ^ b;
        send(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      end
    end
    send(cs ^ flip, 0);
    bus.ByteValid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_corerst"}, {63'd0, CoreRST}, 64'd1);
    chk({tag, "_busy"},    {63'd0, Busy},    64'd0);
    chk({tag, "_done"},    {63'd0, Done},    64'd0);
    chk({tag, "_error"},   {63'd0, Error},   64'd0);
    chk({tag, "_ready"},   {63'd0, bus.ByteReady}, 64'd0);
    chk({tag, "_imwe"},    {63'd0, bus.IMWE}, 64'd0);
    chk({tag, "_imwa"},    {56'd0, bus.IMWA}, 64'd0);
    chk({tag, "_imwd"},    {32'd0, bus.IMWD}, 64'd0);
  endtask

  task automatic two_words();
    words.delete();
    words.push_back(32'h20080005);
    words.push_back(32'h20090007);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0;
    logic [7:0] v;
    bus.ByteIn    = 8'h00;
    bus.ByteValid = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    chk_reset_vals("rst");
    chk("rst_nowrites", 64'(nwr), 64'd0);

    // Good two-word load, ByteValid held high
    two_words();
    load(8'h00, 0);
    chk("good_cycles",  64'(cyc), 64'd11);
    chk("good_done",    {63'd0, Done},    64'd1);
    chk("good_corerst", {63'd0, CoreRST}, 64'd0);
    chk("good_busy",    {63'd0, Busy},    64'd0);
    chk("good_error",   {63'd0, Error},   64'd0);
    chk("good_q_empty", 64'(exp_q.size()), 64'd0);

    // Bad checksum byte 0x0B (true XOR is 0x03)
    load(8'h08, 0);
    chk("bad_error",   {63'd0, Error},   64'd1);
    chk("bad_done",    {63'd0, Done},    64'd0);
    chk("bad_corerst", {63'd0, CoreRST}, 64'd1);
    chk("bad_q_empty", 64'(exp_q.size()), 64'd0);

    // Gaps in ByteValid
    load(8'h00, 3);
    chk("gap_done",    {63'd0, Done},  64'd1);
    chk("gap_error",   {63'd0, Error}, 64'd0);
    chk("gap_q_empty", 64'(exp_q.size()), 64'd0);

    // WordCount = 0
    n0 = nwr;
    do_start(0);
    chk("wc0_done",    {63'd0, Done},    64'd1);
    chk("wc0_corerst", {63'd0, CoreRST}, 64'd0);
    chk("wc0_busy",    {63'd0, Busy},    64'd0);
    repeat (2) @(negedge CLK);
    chk("wc0_nowrite", 64'(nwr - n0), 64'd0);

    // WordCount = 2^AWL + 1
    do_start(257);
    chk("wcbig_error",   {63'd0, Error},   64'd1);
    chk("wcbig_done",    {63'd0, Done},    64'd0);
    chk("wcbig_corerst", {63'd0, CoreRST}, 64'd1);
    chk("wcbig_busy",    {63'd0, Busy},    64'd0);

    // WordCount = 2^AWL
    words.delete();
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      words.push_back({v, ~v, 8'hA5, v ^ 8'h3C});
    end
    load(8'h00, 0);
    chk("full_done",    {63'd0, Done}, 64'd1);
    chk("full_last_a",  64'(last_a),   64'd255);
    chk("full_wrap",    {56'd0, bus.IMWA}, 64'd0);
    chk("full_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset after 6 bytes, then a fresh load
    two_words();
    load_partial();
    RST = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge CLK);
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    load(8'h00, 0);
    chk("after_done",    {63'd0, Done},    64'd1);
    chk("after_corerst", {63'd0, CoreRST}, 64'd0);
    chk("after_q_empty", 64'(exp_q.size()), 64'd0);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic load_partial();
    wr_t e;
    for (int i = 0; i < 2; i++) begin
      e.a = AWL'(i);
      e.d = words[i];
      exp_q.push_back(e);
    end
    do_start(2);
    for (int j = 0; j < 6; j++) begin
      send(words[j/4][31-8*(j%4) -: 8], 0);
    end
    bus.ByteValid = 1'b0;
  endtask

endmodule
